stopwatch_bcd_counter: RTL
==========================

Name: stopwatch_bcd_counter

Overview:
- Timekeeping core of the stopwatch; sits directly upstream of the seven-segment decoders.
- Divides the system clock to a 100 Hz tick and counts elapsed time as MM:SS.cc in six BCD digits.
- Each 4-bit digit output feeds one decoder instance.
- Provides start/stop, clear and lap (display freeze) control from single-cycle pulse inputs; debouncing and edge detection are done upstream.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. CLK_HZ must be an integer multiple of TICK_HZ. DIV = CLK_HZ/TICK_HZ, with DIV >= 2. Benches use small values, e.g. CLK_HZ=400, TICK_HZ=100 gives DIV=4.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start_stop  input  1  one-cycle pulse; toggles run/pause.
- i_clear  input  1  one-cycle pulse; zeroes the count when not running.
- i_lap  input  1  one-cycle pulse; toggles display freeze while running.
- o_min_tens  output  4  displayed minutes tens, 0..5.
- o_min_ones  output  4  displayed minutes ones, 0..9.
- o_sec_tens  output  4  displayed seconds tens, 0..5.
- o_sec_ones  output  4  displayed seconds ones, 0..9.
- o_csec_tens  output  4  displayed centiseconds tens, 0..9.
- o_csec_ones  output  4  displayed centiseconds ones, 0..9.
- o_running  output  1  high in RUN.
- o_lap_active  output  1  high while the display is frozen.
- o_wrap  output  1  one-cycle pulse on rollover 59:59.99 -> 00:00.00.

Behaviour:

Clocking and reset:
- One clock, i_clk.
- i_rst is asynchronous, active-high. While asserted: state=IDLE, prescaler=0, internal count=0, display registers=0, o_running=0, o_lap_active=0, o_wrap=0.
- Reset mid-count discards everything; no partial state survives.

States:
- IDLE: count is 0, prescaler is 0.
  - i_start_stop -> RUN.
  - i_clear: no visible effect.
  - i_lap: ignored.
- RUN: prescaler advances every cycle.
  - i_start_stop -> PAUSED.
  - i_lap toggles the freeze.
  - i_clear is ignored.
- PAUSED: prescaler and count hold their values.
  - i_start_stop -> RUN; resumes from the held prescaler value, so no partial tick is lost or repeated.
  - i_clear -> IDLE; count, prescaler and freeze are all cleared.
  - i_lap is ignored.

Simultaneous pulses:
- In PAUSED, i_clear has priority over i_start_stop: go to IDLE, clear everything, ignore the start.
- In RUN, i_start_stop and i_lap in the same cycle: both take effect (pause, and toggle the freeze).

Prescaler:
- Counts 0..DIV-1 in RUN only.
- On the edge where it equals DIV-1, it returns to 0 and a tick is applied on that same edge.
- A start pulse sampled at edge N from IDLE gives the first increment at edge N+DIV, then every DIV cycles.

BCD cascade (applied per tick):
- csec_ones 9->0 carries into csec_tens.
- csec_tens 9->0 carries into sec_ones.
- sec_ones 9->0 carries into sec_tens.
- sec_tens 5->0 carries into min_ones.
- min_ones 9->0 carries into min_tens.
- min_tens 5->0 is the wrap condition.
- No digit ever holds a value above its limit.
- Wrap: the count becomes 00:00.00, o_wrap is high for exactly the one cycle after that edge, and counting continues in RUN.

Display outputs:
- Registered; updated on the same edge as the internal count whenever the freeze is off. Zero additional latency versus the count.
- First lap pulse: the display holds the count value present before that edge. The internal count keeps running and o_lap_active=1.
- Second lap pulse: the display reloads from the live count on that edge and o_lap_active=0.
- A freeze persists through PAUSED and RUN again; only a second lap pulse, i_clear (from PAUSED) or reset releases it.

Outputs:
- o_running is a registered decode of state: 1 in RUN, 0 otherwise.

Test Plan:
1. DIV=4. Reset, then i_start_stop at edge 10 -> o_csec_ones=1 at edge 14 and =2 at edge 18. o_running=1 from edge 10.
2. Run 100 ticks -> display 00:01.00. Run 6000 ticks from zero -> 01:00.00. Check the sec_tens 5->0 carry into min_ones.
3. Preload-free long run of 360000 ticks -> display 00:00.00, o_wrap high exactly one cycle at that edge, count continues to 00:00.01.
4. Run 37 ticks, pause 2 cycles into a tick period, wait 50 cycles, resume -> next increment arrives after the 2 remaining cycles and display stays 00:00.37 throughout the pause. i_clear while running -> ignored. i_clear in PAUSED together with i_start_stop -> IDLE, all zeros, o_running=0.
5. Lap at 00:00.25 -> display stays 00:00.25 for 30 ticks, o_lap_active=1. Second lap -> display jumps to 00:00.55, o_lap_active=0.
6. Assert i_rst asynchronously mid-cycle during RUN with the freeze active -> all outputs 0 immediately, before the next clock edge. After release, a start pulse counts from 00:00.00.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timekeeping core: divides the system clock to the tick rate and counts MM:SS.cc
// in six BCD digits. It has run/pause, clear and lap (display freeze) control.
module stopwatch_bcd_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_stop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic [3:0] o_csec_tens,
    output logic [3:0] o_csec_ones,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    // Digit 0 is csec_ones, digit 5 is min_tens.
    localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_e;

    state_e          state_q,   state_d;
    logic [PW-1:0]   presc_q,   presc_d;
    logic [5:0][3:0] cnt_q,     cnt_d;
    logic [5:0][3:0] disp_q,    disp_d;
    logic            lap_q,     lap_d;
    logic            wrap_q,    wrap_d;
    logic            running_q, running_d;

    // Adds one centisecond. The MSB of the result is set when min_tens wraps past 5.
    function automatic logic [24:0] bcd_step(input logic [5:0][3:0] cnt);
        logic [5:0][3:0] nxt;
        logic            carry;
        nxt   = cnt;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (cnt[i] >= DIGIT_MAX[i]) begin
                    nxt[i] = 4'd0;
                end else begin
                    nxt[i] = cnt[i] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
        return {carry, nxt};
    endfunction

    always_comb begin
        // NOTE: every signal gets a default value before the case statement, so no latch is inferred.
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        lap_d   = lap_q;
        wrap_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start_stop) state_d = RUN;
            end
            RUN: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d         = '0;
                    {wrap_d, cnt_d} = bcd_step(cnt_q);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (i_start_stop) state_d = PAUSED;
                if (i_lap)        lap_d   = ~lap_q;
            end
            PAUSED: begin
                // Clear wins over a start pulse that arrives in the same cycle.
                if (i_clear) begin
                    state_d = IDLE;
                    presc_d = '0;
                    cnt_d   = '0;
                    lap_d   = 1'b0;
                end else if (i_start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // When the freeze turns on, the display keeps the value it had before this edge.
        // When the freeze turns off, the display loads the new count.
        disp_d    = lap_d ? disp_q : cnt_d;
        running_d = (state_d == RUN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: a reset must clear every bit of state, including the display registers.
        if (i_rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            lap_q     <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its _d value at the same edge.
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
            lap_q     <= lap_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign o_csec_ones  = disp_q[0];
    assign o_csec_tens  = disp_q[1];
    assign o_sec_ones   = disp_q[2];
    assign o_sec_tens   = disp_q[3];
    assign o_min_ones   = disp_q[4];
    assign o_min_tens   = disp_q[5];
    assign o_running    = running_q;
    assign o_lap_active = lap_q;
    assign o_wrap       = wrap_q;

endmodule
